// File: rtl/multibyte_add_seq.sv
// Byte-serial multi-precision adder/subtractor: one 8-bit slice reused NBYTES times.
// Optional signed-overflow flag V enabled by defining ADD_SEQ_OVF_EN.
module multibyte_add_seq #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  op,
    input  logic [8*NBYTES-1:0]   A,
    input  logic [8*NBYTES-1:0]   B,
    output logic [8*NBYTES-1:0]   S,
    output logic                  C_out,
    output logic                  busy,
    output logic                  done,
    output logic                  V
);

    localparam int unsigned W    = 8 * NBYTES;
    localparam int unsigned IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDXW-1:0]   idx;
    logic              carry;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic              op_q;

    logic [7:0]        a_byte;
    logic [7:0]        b_byte;
    logic [7:0]        sum_byte;
    logic              slice_cout;
    logic              last;

    // Single shared slice; subtract is A + ~B + 1 with the +1 seeded into carry.
    always_comb begin
        a_byte = a_q[8*idx +: 8];
        b_byte = op_q ? ~b_q[8*idx +: 8] : b_q[8*idx +: 8];
        {slice_cout, sum_byte} = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry};
        last = (idx == IDXW'(NBYTES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= 1'b0;
            S     <= '0;
            C_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        op_q  <= op;
                        S     <= '0;
                        idx   <= '0;
                        carry <= op;
                    end
                end
                RUN: begin
                    S[8*idx +: 8] <= sum_byte;
                    carry         <= slice_cout;
                    if (last) begin
                        idx   <= '0;
                        C_out <= slice_cout;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ADD_SEQ_OVF_EN
    // Carry into bit 7 of the top byte recovered as a ^ b ^ sum at that bit.
    logic msb_cin;
    assign msb_cin = a_byte[7] ^ b_byte[7] ^ sum_byte[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            V <= 1'b0;
        end else if (state == RUN && last) begin
            V <= msb_cin ^ slice_cout;
        end
    end
`else
    assign V = 1'b0;
`endif

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Scoreboard bench for multibyte_add_seq (NBYTES=4): driver queues expected results,
// a negedge monitor checks every done pulse for value, flags, latency and busy length.
module tb_multibyte_add_seq;

    localparam int unsigned NB = 4;
    localparam int unsigned W  = 8 * NB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          op_i = 1'b0;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic [W-1:0]  S;
    logic          C_out;
    logic          busy;
    logic          done;
    logic          V;

    multibyte_add_seq #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op_i),
        .A     (A),
        .B     (B),
        .S     (S),
        .C_out (C_out),
        .busy  (busy),
        .done  (done),
        .V     (V)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        int unsigned  acc;
    } exp_t;

    exp_t         q[$];
    int unsigned  cyc = 0;
    int unsigned  tests = 0;
    int unsigned  fails = 0;
    logic [W-1:0] last_s = '0;
    logic         last_c = 1'b0;
    logic         last_v = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the whole words.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input int unsigned acc);
        exp_t   e;
        longint sa;
        longint sb;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            e.s = a - b;
            e.c = (a >= b);
            r   = sa - sb;
        end else begin
            e.s = a + b;
            e.c = ((longint'(a) + longint'(b)) >= 64'h1_0000_0000);
            r   = sa + sb;
        end
`ifdef ADD_SEQ_OVF_EN
        e.v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
`else
        e.v = 1'b0;
`endif
        e.acc = acc;
        return e;
    endfunction

    // Monitor
    int unsigned busy_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (busy && done) chk("busy_done_exclusive", 1, 0);
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("S", S, e.s);
                    chk("C_out", C_out, e.c);
                    chk("V", V, e.v);
                    chk("latency", cyc - e.acc, NB);
                    chk("busy_cycles", busy_cnt, NB);
                    last_s = e.s;
                    last_c = e.c;
                    last_v = e.v;
                end
                busy_cnt = 0;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input int unsigned gap);
        int unsigned n = 0;
        while ((busy || done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 1, 0);
        chk("hold_S", S, last_s);
        chk("hold_C", C_out, last_c);
        chk("hold_V", V, last_v);
        A = a;
        B = b;
        op_i = sub;
        start = 1'b1;
        q.push_back(model(a, b, sub, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        A = $urandom;
        B = $urandom;
        op_i = 1'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    function automatic logic [W-1:0] rnd_word();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (tests %0d)", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_S", S, 0);
        chk("reset_C", C_out, 0);
        chk("reset_V", V, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1);
        do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 0);
        do_op(32'h0000_0007, 32'h0000_0005, 1'b1, 2);
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
        do_op(32'h0000_0000, 32'h0000_0001, 1'b1, 0);
        do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 0);
        do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            do_op(rnd_word(), rnd_word(), 1'($urandom), $urandom_range(0, 3));
        end

        // start held high with operands churning: only acceptances every NB+2 edges count
        begin
            int unsigned n = 0;
            int unsigned t0;
            while ((busy || done) && n < 100) begin
                @(negedge clk);
                n++;
            end
            A = 32'h1234_5678;
            B = 32'h0FED_CBA9;
            op_i = 1'b0;
            start = 1'b1;
            t0 = cyc + 1;
            q.push_back(model(A, B, op_i, t0));
            for (int k = 1; k <= int'(NB) + 2; k++) begin
                @(negedge clk);
                A = $urandom;
                B = $urandom;
                op_i = 1'($urandom);
                if (k == int'(NB) + 2) q.push_back(model(A, B, op_i, t0 + NB + 2));
            end
            @(negedge clk);
            start = 1'b0;
        end

        // asynchronous reset after two RUN edges aborts the operation
        do_op(32'h0102_0304, 32'h0101_0101, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_S", S, 0);
        chk("abort_C", C_out, 0);
        chk("abort_V", V, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        q.delete();
        last_s = '0;
        last_c = 1'b0;
        last_v = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_hold_done", done, 0);
        rst_n = 1'b1;
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        do_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0);

        begin
            int unsigned n = 0;
            while (q.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("drain", q.size(), 0);
        end
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multibyte_add_seq.md
MULTIBYTE_ADD_SEQ -- requirements
Module: multibyte_add_seq

Interface
REQ-001 Parameter: NBYTES, default 4, number of 8-bit slices per operation (legal 2..16).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request; sampled only in IDLE.
REQ-005 Port: op  input  1  0 = add (A+B), 1 = subtract (A-B).
REQ-006 Port: A  input  8*NBYTES  operand A; byte 0 is bits [7:0].
REQ-007 Port: B  input  8*NBYTES  operand B; byte 0 is bits [7:0].
REQ-008 Port: S  output  8*NBYTES  result register.
REQ-009 Port: C_out  output  1  carry out of the top byte; for subtract, 1 = no borrow.
REQ-010 Port: busy  output  1  high while in RUN.
REQ-011 Port: done  output  1  one-cycle completion pulse.
REQ-012 Port: V  output  1  signed overflow flag (REQ-030).

Function
REQ-013 The block SHALL contain exactly one 8-bit add slice with carry-in, reused once per byte.
REQ-014 States SHALL be IDLE, RUN and DONE.
REQ-015 In IDLE with start=1 at a rising edge, the block SHALL:
  - latch A, B and op;
  - clear S;
  - set byte index to 0;
  - set carry register to op (1 for subtract);
  - enter RUN.
REQ-016 In IDLE with start=0, the state SHALL remain IDLE and all outputs SHALL hold.
REQ-017 Each RUN edge SHALL compute byte[idx] = A_byte + (op ? ~B_byte : B_byte) + carry.
  - The result is written into S[8*idx+7:8*idx].
  - The slice carry-out is written into the carry register.
  - idx increments by 1.
REQ-018 On the RUN edge that processes idx=NBYTES-1, the block SHALL:
  - load C_out from that slice's carry-out;
  - set done=1;
  - enter DONE.
REQ-019 From DONE, the next edge SHALL return the block to IDLE with done=0, so done is high for exactly one cycle.
REQ-020 Latency: done SHALL be high in the cycle after the NBYTES-th RUN edge, i.e. NBYTES cycles after the start edge.
REQ-021 Minimum start-to-start spacing SHALL be NBYTES+2 cycles.
REQ-022 start SHALL be ignored in RUN and DONE; the request is not queued.
REQ-023 Changes on A, B or op after the start edge SHALL NOT affect the in-flight result.
REQ-024 S, C_out and V SHALL hold their values from done until the next accepted start.
REQ-025 Arithmetic SHALL be modulo 2^(8*NBYTES) with natural wrap-around:
  - 0xFF..FF + 1 gives S=0, C_out=1.
  - 0 - 1 gives S=0xFF..FF, C_out=0.
REQ-026 busy SHALL equal (state==RUN), and busy and done SHALL never be high together.

Reset
REQ-027 While rst_n=0, regardless of clock, the block SHALL immediately force:
  - state IDLE, idx 0, carry register 0;
  - S=0, C_out=0, busy=0, done=0, V=0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no done pulse, and the partial S SHALL be discarded (cleared).
REQ-029 After rst_n deasserts, the first rising edge SHALL already accept start.

Configuration
REQ-030 Macro ADD_SEQ_OVF_EN:
  - Defined: V SHALL be loaded with the same timing as C_out, equal to carry-into-MSB XOR carry-out-of-MSB of the top byte.
  - Not defined: V SHALL be tied to 0 and no overflow logic SHALL be synthesised.
  - The port list SHALL be identical in both builds.

Verification (NBYTES=4)
REQ-031 Add 0x000000FF + 0x00000001 -> S=0x00000100, C_out=0, V=0; done exactly 4 cycles after the start edge, busy high for 4 cycles.
REQ-032 Add 0xFFFFFFFF + 0x00000001 -> S=0x00000000, C_out=1; V=0 (with ADD_SEQ_OVF_EN).
REQ-033 Subtract 0x00000005 - 0x00000007 -> S=0xFFFFFFFE, C_out=0; subtract 7-5 -> S=0x00000002, C_out=1.
REQ-034 Add 0x7FFFFFFF + 0x00000001 -> S=0x80000000:
  - with ADD_SEQ_OVF_EN: V=1;
  - without it: V=0.
REQ-035 Hold start=1 and change A/B during RUN -> exactly one done pulse; result matches operands latched at the accepted edge; next acceptance no earlier than 6 cycles after the first.
REQ-036 Assert rst_n=0 after 2 RUN edges -> outputs zero immediately, no done pulse; a new start after release completes normally.
